// File: rtl/dac_write_arbiter.sv
// Arbitrates PID-loop and host DAC codes into two-byte SPI frames.
// Each requester has one pending slot; the host wins ties and frames are separated by a GAP.
module dac_write_arbiter #(
    parameter int          GAP_CYCLES = 50,
    parameter logic [15:0] DAC_INIT   = 16'h9E23
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        loop_req,
    input  logic [15:0] loop_val,
    input  logic        host_req,
    input  logic [15:0] host_val,
    input  logic        host_override,
    input  logic        spi_tx_ready,
    output logic [7:0]  spi_tx_byte,
    output logic        spi_tx_dv,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] dac_val_cur,
    output logic [7:0]  drop_cnt,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, GAP} state_t;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    state_t        state_q, state_d;
    logic [15:0]   frame_q, frame_d;
    logic [7:0]    byte_q, byte_d;
    logic          seen_low_q, seen_low_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   dac_q, dac_d;
    logic          done_q, done_d;
    logic [7:0]    drop_q, drop_d;
    logic          host_v_q, host_v_d, loop_v_q, loop_v_d;
    logic [15:0]   host_val_q, host_val_d, loop_val_q, loop_val_d;
    logic          grant_host, grant_loop, loop_drop;

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        byte_d     = byte_q;
        seen_low_d = seen_low_q;
        gap_d      = gap_q;
        dac_d      = dac_q;
        done_d     = 1'b0;
        spi_tx_dv  = 1'b0;
        grant_host = 1'b0;
        grant_loop = 1'b0;
        case (state_q)
            IDLE: begin
                if (spi_tx_ready) begin
                    if (host_v_q) begin
                        grant_host = 1'b1;
                        frame_d    = host_val_q;
                        byte_d     = host_val_q[15:8];
                        state_d    = SEND_HI;
                    end else if (loop_v_q && !host_override) begin
                        grant_loop = 1'b1;
                        frame_d    = loop_val_q;
                        byte_d     = loop_val_q[15:8];
                        state_d    = SEND_HI;
                    end
                end
            end
            SEND_HI: begin
                // Strobe only while the master is ready; otherwise hold here.
                if (spi_tx_ready) begin
                    spi_tx_dv  = 1'b1;
                    seen_low_d = 1'b0;
                    state_d    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (!spi_tx_ready) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    byte_d  = frame_q[7:0];
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                if (spi_tx_ready) begin
                    spi_tx_dv  = 1'b1;
                    seen_low_d = 1'b0;
                    state_d    = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!spi_tx_ready) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    dac_d   = frame_q;
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (GAP_CYCLES == 0 || gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A strobe in the same cycle its slot is granted is a fresh request, not an overwrite.
    always_comb begin
        host_v_d   = host_v_q & ~grant_host;
        host_val_d = host_val_q;
        if (host_req) begin
            host_v_d   = 1'b1;
            host_val_d = host_val;
        end
        loop_v_d   = loop_v_q & ~grant_loop;
        loop_val_d = loop_val_q;
        if (host_override) begin
            loop_v_d = 1'b0;
        end else if (loop_req) begin
            loop_v_d   = 1'b1;
            loop_val_d = loop_val;
        end
        loop_drop = loop_req && (host_override || (loop_v_q && !grant_loop));
        drop_d    = (loop_drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            byte_q     <= '0;
            seen_low_q <= 1'b0;
            gap_q      <= '0;
            dac_q      <= DAC_INIT;
            done_q     <= 1'b0;
            drop_q     <= '0;
            host_v_q   <= 1'b0;
            host_val_q <= '0;
            loop_v_q   <= 1'b0;
            loop_val_q <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            byte_q     <= byte_d;
            seen_low_q <= seen_low_d;
            gap_q      <= gap_d;
            dac_q      <= dac_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
            host_v_q   <= host_v_d;
            host_val_q <= host_val_d;
            loop_v_q   <= loop_v_d;
            loop_val_q <= loop_val_d;
        end
    end

    assign spi_tx_byte = byte_q;
    assign busy        = (state_q != IDLE);
    assign frame_done  = done_q;
    assign dac_val_cur = dac_q;
    assign drop_cnt    = drop_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Directed bench for dac_write_arbiter with a 20-cycle-busy SPI ready responder.
module tb_dac_write_arbiter;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic        loop_req = 1'b0;
    logic [15:0] loop_val = '0;
    logic        host_req = 1'b0;
    logic [15:0] host_val = '0;
    logic        host_override = 1'b0;
    logic        spi_tx_ready;
    logic [7:0]  spi_tx_byte;
    logic        spi_tx_dv;
    logic        busy;
    logic        frame_done;
    logic [15:0] dac_val_cur;
    logic [7:0]  drop_cnt;
    logic [2:0]  dbg_state_o;

    logic        model_ready = 1'b1;
    logic        force_low = 1'b0;
    int unsigned model_cnt = 0;

    int checks = 0;
    int errors = 0;

    dac_write_arbiter dut (
        .clk50(clk50), .reset(reset),
        .loop_req(loop_req), .loop_val(loop_val),
        .host_req(host_req), .host_val(host_val),
        .host_override(host_override), .spi_tx_ready(spi_tx_ready),
        .spi_tx_byte(spi_tx_byte), .spi_tx_dv(spi_tx_dv), .busy(busy),
        .frame_done(frame_done), .dac_val_cur(dac_val_cur),
        .drop_cnt(drop_cnt), .dbg_state_o(dbg_state_o)
    );

    always #10 clk50 = ~clk50;

    // SPI master stand-in: drops ready after accepting a byte, returns it 20 cycles later.
    always @(posedge clk50) begin
        if (reset) begin
            model_ready <= 1'b1;
            model_cnt   <= 0;
        end else if (spi_tx_dv) begin
            model_ready <= 1'b0;
            model_cnt   <= 20;
        end else if (model_cnt != 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) model_ready <= 1'b1;
        end
    end
    assign spi_tx_ready = model_ready & ~force_low;

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_dv(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (spi_tx_dv !== 1'b1 && n < max);
        chk("dv_timeout", {15'd0, spi_tx_dv}, 16'd1);
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_done !== 1'b1 && n < max);
        chk("done_timeout", {15'd0, frame_done}, 16'd1);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max) begin
            tick();
            n++;
        end
        chk("idle_timeout", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        int n;
        int dv_seen;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_dv", {15'd0, spi_tx_dv}, 16'd0);
        chk("rst_byte", {8'd0, spi_tx_byte}, 16'd0);
        chk("rst_done", {15'd0, frame_done}, 16'd0);
        chk("rst_dac", dac_val_cur, 16'h9E23);
        chk("rst_drop", {8'd0, drop_cnt}, 16'd0);
        chk("rst_state", {13'd0, dbg_state_o}, 16'd0);

        // Single loop write 0x1234, latency N+2 and full frame timing
        loop_req = 1'b1; loop_val = 16'h1234;
        tick();
        loop_req = 1'b0;
        chk("t1_n1_dv", {15'd0, spi_tx_dv}, 16'd0);
        chk("t1_n1_busy", {15'd0, busy}, 16'd0);
        tick();
        chk("t1_n2_dv", {15'd0, spi_tx_dv}, 16'd1);
        chk("t1_hi_byte", {8'd0, spi_tx_byte}, 16'h0012);
        chk("t1_busy", {15'd0, busy}, 16'd1);
        wait_dv(100, n);
        chk("t1_lo_lat", 16'(n), 16'd22);
        chk("t1_lo_byte", {8'd0, spi_tx_byte}, 16'h0034);
        wait_done(100, n);
        chk("t1_done_lat", 16'(n), 16'd22);
        chk("t1_dac", dac_val_cur, 16'h1234);
        tick();
        chk("t1_done_pulse", {15'd0, frame_done}, 16'd0);
        wait_idle(200);

        // Simultaneous host and loop requests: host first, loop after the gap
        host_req = 1'b1; host_val = 16'hAAAA;
        loop_req = 1'b1; loop_val = 16'h5555;
        tick();
        host_req = 1'b0; loop_req = 1'b0;
        tick();
        chk("t2_hi_dv", {15'd0, spi_tx_dv}, 16'd1);
        chk("t2_hi_byte", {8'd0, spi_tx_byte}, 16'h00AA);
        wait_dv(100, n);
        chk("t2_lo_byte", {8'd0, spi_tx_byte}, 16'h00AA);
        wait_done(100, n);
        chk("t2_dac_a", dac_val_cur, 16'hAAAA);
        wait_dv(200, n);
        chk("t2_gap", 16'(n), 16'd51);
        chk("t2_hi2_byte", {8'd0, spi_tx_byte}, 16'h0055);
        wait_dv(100, n);
        chk("t2_lo2_byte", {8'd0, spi_tx_byte}, 16'h0055);
        wait_done(100, n);
        chk("t2_dac_5", dac_val_cur, 16'h5555);
        chk("t2_drop", {8'd0, drop_cnt}, 16'd0);
        wait_idle(200);

        // Three loop requests during one frame: last one wins, two drops
        loop_req = 1'b1; loop_val = 16'hBEEF;
        tick();
        loop_req = 1'b0;
        tick();
        chk("t3_hi_byte", {8'd0, spi_tx_byte}, 16'h00BE);
        for (int i = 1; i <= 3; i++) begin
            loop_req = 1'b1; loop_val = 16'(i);
            tick();
        end
        loop_req = 1'b0;
        wait_dv(100, n);
        chk("t3_lo_byte", {8'd0, spi_tx_byte}, 16'h00EF);
        wait_done(100, n);
        chk("t3_dac_beef", dac_val_cur, 16'hBEEF);
        wait_dv(200, n);
        chk("t3_hi2_byte", {8'd0, spi_tx_byte}, 16'h0000);
        wait_dv(100, n);
        chk("t3_lo2_byte", {8'd0, spi_tx_byte}, 16'h0003);
        wait_done(100, n);
        chk("t3_dac_3", dac_val_cur, 16'h0003);
        chk("t3_drop", {8'd0, drop_cnt}, 16'd2);
        wait_idle(200);

        // Raising override clears a pending loop slot without counting
        force_low = 1'b1;
        loop_req = 1'b1; loop_val = 16'h7777;
        tick();
        loop_req = 1'b0;
        host_override = 1'b1;
        tick();
        host_override = 1'b0;
        force_low = 1'b0;
        dv_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (spi_tx_dv === 1'b1) dv_seen++;
        end
        chk("t4_clear_dv", 16'(dv_seen), 16'd0);
        chk("t4_clear_drop", {8'd0, drop_cnt}, 16'd2);

        // Override with 300 loop strobes: no SPI activity, drop count saturates
        host_override = 1'b1;
        dv_seen = 0;
        for (int i = 0; i < 300; i++) begin
            loop_req = 1'b1; loop_val = 16'(i);
            tick();
            if (spi_tx_dv === 1'b1 || busy === 1'b1) dv_seen++;
        end
        loop_req = 1'b0;
        tick();
        host_override = 1'b0;
        chk("t4_ovr_activity", 16'(dv_seen), 16'd0);
        chk("t4_drop_sat", {8'd0, drop_cnt}, 16'h00FF);

        // Ready held low with a pending request: dv only one cycle after ready rises
        force_low = 1'b1;
        host_req = 1'b1; host_val = 16'h4321;
        tick();
        host_req = 1'b0;
        dv_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (spi_tx_dv === 1'b1) dv_seen++;
        end
        chk("t5_no_dv", 16'(dv_seen), 16'd0);
        chk("t5_idle", {15'd0, busy}, 16'd0);
        force_low = 1'b0;
        tick();
        chk("t5_dv", {15'd0, spi_tx_dv}, 16'd1);
        chk("t5_hi_byte", {8'd0, spi_tx_byte}, 16'h0043);
        tick();
        chk("t5_wait_hi", {13'd0, dbg_state_o}, 16'd2);

        // Reset during WAIT_HI aborts the frame; strobes in the reset cycle are ignored
        reset = 1'b1;
        loop_req = 1'b1; loop_val = 16'h1111;
        host_req = 1'b1; host_val = 16'h2222;
        tick();
        reset = 1'b0; loop_req = 1'b0; host_req = 1'b0;
        chk("t6_dv", {15'd0, spi_tx_dv}, 16'd0);
        chk("t6_busy", {15'd0, busy}, 16'd0);
        chk("t6_dac", dac_val_cur, 16'h9E23);
        chk("t6_drop", {8'd0, drop_cnt}, 16'd0);
        chk("t6_byte", {8'd0, spi_tx_byte}, 16'd0);
        dv_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (spi_tx_dv === 1'b1 || frame_done === 1'b1 || busy === 1'b1) dv_seen++;
        end
        chk("t6_quiet", 16'(dv_seen), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_write_arbiter.md
DAC_WRITE_ARBITER -- requirements
Module: dac_write_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 50: minimum idle clk50 cycles between end of one DAC frame and start of the next.
REQ-002 SHALL have parameter DAC_INIT, default 16'h9E23: reset value of dac_val_cur.
REQ-003 clk50  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 loop_req  input  1  one-cycle strobe from the PID loop; loop_val valid in the same cycle.
REQ-006 loop_val  input  16  DAC code requested by the PID loop.
REQ-007 host_req  input  1  one-cycle strobe from the UART monitor register path; host_val valid in the same cycle.
REQ-008 host_val  input  16  DAC code requested by the host.
REQ-009 host_override  input  1  level; while high, loop requests are discarded.
REQ-010 spi_tx_ready  input  1  SPI master ready; high when it can accept a byte.
REQ-011 spi_tx_byte  output  8  byte presented to the SPI master.
REQ-012 spi_tx_dv  output  1  one-cycle byte-valid strobe to the SPI master.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 frame_done  output  1  one-cycle pulse when the low byte has been accepted and the SPI master has returned ready.
REQ-015 dac_val_cur  output  16  last code fully written to the DAC.
REQ-016 drop_cnt  output  8  saturating count of loop requests lost (override or overwrite).

Function
REQ-017 SHALL hold one pending slot per requester (valid bit + 16-bit value); a strobe loads its slot on the next edge.
REQ-018 A strobe arriving while its slot is already valid SHALL overwrite the value; for the loop slot drop_cnt SHALL increment by 1.
REQ-019 loop_req while host_override=1 SHALL not load the slot and SHALL increment drop_cnt; raising host_override SHALL clear a valid loop slot (no count).
REQ-020 drop_cnt SHALL saturate at 8'hFF; two drop causes in one cycle count once.
REQ-021 FSM states: IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, GAP.
REQ-022 IDLE -> SEND_HI when any slot valid and spi_tx_ready=1; host slot wins over loop slot; the winning value latches into a frame register and its slot clears in the same edge.
REQ-023 SEND_HI: spi_tx_byte=frame[15:8], spi_tx_dv=1 for exactly one cycle, then WAIT_HI.
REQ-024 WAIT_HI: wait for spi_tx_ready to fall then rise (edge-tracked); on rise -> SEND_LO.
REQ-025 SEND_LO: spi_tx_byte=frame[7:0], spi_tx_dv=1 one cycle, then WAIT_LO.
REQ-026 WAIT_LO: on ready fall-then-rise -> GAP; same edge dac_val_cur<=frame and frame_done pulses.
REQ-027 GAP: count GAP_CYCLES cycles, then IDLE; GAP_CYCLES=0 SHALL go directly to IDLE next cycle.
REQ-028 spi_tx_dv SHALL never assert when spi_tx_ready=0; spi_tx_byte holds its last value outside SEND states.
REQ-029 Latency: strobe in cycle N with FSM idle and ready high SHALL give spi_tx_dv high in cycle N+2.
REQ-030 Requests arriving during a frame SHALL be queued in slots, never corrupt the frame in flight.
REQ-031 Simultaneous host_req and loop_req SHALL both load; host frame goes first, loop frame follows after GAP.

Reset
REQ-032 reset=1 SHALL force on the next edge: state IDLE, slots invalid, spi_tx_dv=0, spi_tx_byte=0, busy=0, frame_done=0, drop_cnt=0, dac_val_cur=DAC_INIT, GAP counter 0.
REQ-033 reset mid-frame SHALL abort the frame without completing it; dac_val_cur returns to DAC_INIT; no frame_done.
REQ-034 Strobes in the reset cycle SHALL be ignored.

Verification
REQ-035 Single loop write 16'h1234, ready model 20-cycle busy -> dv with 8'h12 at N+2, dv with 8'h34 after ready returns, frame_done, dac_val_cur=16'h1234.
REQ-036 host_req 16'hAAAA and loop_req 16'h5555 same cycle -> frame AAAA, ≥50-cycle gap, frame 5555; drop_cnt=0.
REQ-037 Three loop_req (1,2,3) during one frame -> next frame sends 3; drop_cnt=2.
REQ-038 host_override=1, 300 loop_req strobes -> no SPI activity, drop_cnt=8'hFF.
REQ-039 reset asserted during WAIT_HI -> dv stays low, dac_val_cur=16'h9E23, busy=0 next cycle.
REQ-040 spi_tx_ready held low with pending request -> no dv until ready rises; dv then at ready-high+1.
